// File: rtl/freq_spec_if.sv
// Magnitude-update handshake between the filter bank (master) and the
// spectrum bar controller (slave).
`timescale 1ns/1ps
interface freq_spec_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_band;
  logic [15:0] in_mag;

  modport master (output in_valid, in_band, in_mag, input in_ready);
  modport slave  (input in_valid, in_band, in_mag, output in_ready);
endinterface

// File: rtl/freq_spec_ctrl.sv
// 12-bar spectrum controller: shadows per-band targets, commits them once per frame
// with instant attack and rate-limited decay. Optional peak hold: FREQ_PEAK_HOLD_EN.
`timescale 1ns/1ps
module freq_spec_ctrl #(
  parameter int MAG_SHIFT   = 7,
  parameter int DECAY       = 4
`ifdef FREQ_PEAK_HOLD_EN
  , parameter int HOLD_FRAMES = 8
`endif
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       frame_start,
  freq_spec_if.slave bus,
  output logic       bad_band,
  output logic       commit_done,
  output logic [8:0] b31,
  output logic [8:0] b72,
  output logic [8:0] b150,
  output logic [8:0] b250,
  output logic [8:0] b440,
  output logic [8:0] b630,
  output logic [8:0] b1k,
  output logic [8:0] b2_5k,
  output logic [8:0] b5k,
  output logic [8:0] b8k,
  output logic [8:0] b14k,
  output logic [8:0] b20k
);

  localparam int         NBANDS     = 12;
  localparam logic [8:0] EMPTY_ROW  = 9'd480;
  localparam logic [9:0] DECAY_STEP = 10'(DECAY);

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t     state;
  logic [3:0] idx;
  logic       ready_q;
  logic [8:0] tgt [NBANDS];
  logic [8:0] cur [NBANDS];
`ifdef FREQ_PEAK_HOLD_EN
  logic [3:0] hold [NBANDS];
`endif

  logic [15:0] h_full;
  logic [8:0]  wr_row;
  logic        accept;
  logic        band_ok;
  logic [8:0]  cur_sel;
  logic [8:0]  tgt_sel;
  logic [9:0]  stepped;
  logic [8:0]  decay_row;

  always_comb begin
    h_full    = bus.in_mag >> MAG_SHIFT;
    // Heights of 480 or more saturate to a full bar (top row 0).
    wr_row    = (h_full >= 16'(EMPTY_ROW)) ? 9'd0 : EMPTY_ROW - h_full[8:0];
    accept    = bus.in_valid && ready_q;
    band_ok   = (bus.in_band < 4'(NBANDS));
    cur_sel   = cur[idx];
    tgt_sel   = tgt[idx];
    stepped   = {1'b0, cur_sel} + DECAY_STEP;
    decay_row = (stepped < {1'b0, tgt_sel}) ? stepped[8:0] : tgt_sel;
  end

  // NOTE: the shadow and bar arrays are only 24 words, so they sit on the async
  // reset; a reset mid-commit must blank every bar immediately.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      ready_q     <= 1'b1;
      bad_band    <= 1'b0;
      commit_done <= 1'b0;
      for (int i = 0; i < NBANDS; i++) begin
        tgt[i] <= EMPTY_ROW;
        cur[i] <= EMPTY_ROW;
`ifdef FREQ_PEAK_HOLD_EN
        hold[i] <= '0;
`endif
      end
    end else begin
      bad_band    <= 1'b0;
      commit_done <= 1'b0;

      // An update accepted alongside frame_start lands before band 0 is committed.
      if (accept) begin
        if (band_ok) tgt[bus.in_band] <= wr_row;
        else         bad_band         <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= COMMIT;
            ready_q <= 1'b0;
            idx     <= '0;
          end
        end
        COMMIT: begin
          if (tgt_sel <= cur_sel) begin
            cur[idx] <= tgt_sel;
`ifdef FREQ_PEAK_HOLD_EN
            if (tgt_sel < cur_sel) hold[idx] <= 4'(HOLD_FRAMES);
`endif
          end
`ifdef FREQ_PEAK_HOLD_EN
          else if (hold[idx] != 4'd0) hold[idx] <= hold[idx] - 4'd1;
`endif
          else cur[idx] <= decay_row;

          if (idx == 4'(NBANDS - 1)) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            commit_done <= 1'b1;
            idx         <= '0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = ready_q;

  assign b31   = cur[0];
  assign b72   = cur[1];
  assign b150  = cur[2];
  assign b250  = cur[3];
  assign b440  = cur[4];
  assign b630  = cur[5];
  assign b1k   = cur[6];
  assign b2_5k = cur[7];
  assign b5k   = cur[8];
  assign b8k   = cur[9];
  assign b14k  = cur[10];
  assign b20k  = cur[11];

endmodule

// File: tb/tb_freq_spec_ctrl.sv
// Scoreboard bench for freq_spec_ctrl: each frame_start pushes the expected bar set,
// a monitor pops it when commit_done pulses; directed checks cover timing corners.
`timescale 1ns/1ps
module tb_freq_spec_ctrl;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic bad_band, commit_done;
  logic [8:0] b31, b72, b150, b250, b440, b630, b1k, b2_5k, b5k, b8k, b14k, b20k;

  freq_spec_if bus ();

  freq_spec_ctrl dut (
    .clk50       (clk50),
    .reset       (reset),
    .frame_start (frame_start),
    .bus         (bus),
    .bad_band    (bad_band),
    .commit_done (commit_done),
    .b31 (b31), .b72 (b72), .b150 (b150), .b250 (b250),
    .b440 (b440), .b630 (b630), .b1k (b1k), .b2_5k (b2_5k),
    .b5k (b5k), .b8k (b8k), .b14k (b14k), .b20k (b20k)
  );

  always #10 clk50 = ~clk50;

  typedef logic [11:0][8:0] bars_t;

  bars_t dut_bars;
  assign dut_bars = {b20k, b14k, b8k, b5k, b2_5k, b1k, b630, b440, b250, b150, b72, b31};

  int    checks = 0;
  int    errors = 0;
  bars_t exp_q [$];
  int    bad_q [$];
  int    m_cur [12];
  int    m_tgt [12];
  int    m_hold [12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference bar model, updated at the moment frame_start is issued.
  function automatic bars_t model_commit();
    bars_t r;
    for (int k = 0; k < 12; k++) begin
      if (m_tgt[k] <= m_cur[k]) begin
`ifdef FREQ_PEAK_HOLD_EN
        if (m_tgt[k] < m_cur[k]) m_hold[k] = 8;
`endif
        m_cur[k] = m_tgt[k];
      end else begin
`ifdef FREQ_PEAK_HOLD_EN
        if (m_hold[k] != 0) m_hold[k]--;
        else
`endif
        m_cur[k] = (m_cur[k] + 4 < m_tgt[k]) ? m_cur[k] + 4 : m_tgt[k];
      end
      r[k] = 9'(m_cur[k]);
    end
    return r;
  endfunction

  function automatic int row_of(input int mag);
    int h;
    h = mag >> 7;
    if (h > 480) h = 480;
    return 480 - h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 12; k++) begin
      m_cur[k] = 480; m_tgt[k] = 480; m_hold[k] = 0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a finished commit or a bad band.
  always @(negedge clk50) begin
    if (!reset) begin
      if (commit_done) begin
        if (exp_q.size() == 0) check("unexpected_commit_done", 1, 0);
        else begin
          bars_t e;
          e = exp_q.pop_front();
          for (int k = 0; k < 12; k++) check($sformatf("frame_bar%0d", k), dut_bars[k], e[k]);
        end
      end
      if (bad_band) begin
        if (bad_q.size() == 0) check("unexpected_bad_band", 1, 0);
        else void'(bad_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic send(input int band, input int mag);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_band  = 4'(band);
    bus.in_mag   = 16'(mag);
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!bus.in_ready) begin
      check("send_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    bus.in_valid = 1'b0;
    if (band < 12) begin
      m_tgt[band] = row_of(mag);
      check("bad_band_quiet", bad_band, 0);
    end else begin
      bad_q.push_back(band);
      check("bad_band_next_cycle", bad_band, 1);
    end
  endtask

  // Issues frame_start in the current cycle T and leaves the bench in cycle T+14.
  task automatic frame(output logic [8:0] b0_t1, output logic [8:0] b0_t2);
    frame_start = 1'b1;
    exp_q.push_back(model_commit());
    tick();
    frame_start = 1'b0;
    b0_t1 = b31;
    b0_t2 = 'x;
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("ready_low_T%0d", c), bus.in_ready, 0);
      tick();
      if (c == 1) b0_t2 = b31;
    end
    check("ready_back_T13", bus.in_ready, 1);
    check("commit_done_T13", commit_done, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] t1, t2;
    int waited;
    int e;
    bus.in_valid = 1'b0;
    bus.in_band  = '0;
    bus.in_mag   = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    for (int k = 0; k < 12; k++) check($sformatf("reset_bar%0d", k), dut_bars[k], 480);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_bad_band", bad_band, 0);
    check("reset_commit_done", commit_done, 0);

    // Empty frame
    frame(t1, t2);

    // Band 0 mag 0x1000: row 448 appears at T+2, not before
    send(0, 16'h1000);
    frame(t1, t2);
    check("b31_at_T1", t1, 480);
    check("b31_at_T2", t2, 448);
    check("b72_untouched", b72, 480);

    // Band 3 to row 380, then mag 0: rate-limited fall to 480 without overshoot
    send(3, 16'h3200);
    frame(t1, t2);
    check("b250_attack", b250, 380);
    send(3, 0);
    for (int n = 1; n <= 34; n++) begin
`ifdef FREQ_PEAK_HOLD_EN
      e = (n <= 8) ? 380 : 380 + 4 * (n - 8);
`else
      e = 380 + 4 * n;
`endif
      if (e > 480) e = 480;
      frame(t1, t2);
      check($sformatf("b250_decay_%0d", n), b250, e);
    end

    // Saturation and invalid band
    send(11, 16'hFFFF);
    send(13, 16'h1234);
    frame(t1, t2);
    check("b20k_saturated", b20k, 0);

    // Update coinciding with frame_start, second update stalls through the commit
    bus.in_valid = 1'b1;
    bus.in_band  = 4'd7;
    bus.in_mag   = 16'h2000;
    frame_start  = 1'b1;
    check("concurrent_ready", bus.in_ready, 1);
    m_tgt[7] = row_of(16'h2000);
    exp_q.push_back(model_commit());
    tick();
    frame_start  = 1'b0;
    bus.in_band  = 4'd8;
    bus.in_mag   = 16'h0800;
    waited = 0;
    while (!bus.in_ready && waited < 40) begin
      tick();
      waited++;
    end
    check("stall_cycles", waited, 12);
    check("stall_commit_done", commit_done, 1);
    check("b2_5k_included", b2_5k, 416);
    check("b5k_not_yet", b5k, 480);
    tick();
    bus.in_valid = 1'b0;
    m_tgt[8] = row_of(16'h0800);
    frame(t1, t2);
    check("b5k_after_stall", b5k, 464);

    // Band 5 attack to 280 then release
    send(5, 25600);
    frame(t1, t2);
    check("b630_attack", b630, 280);
    send(5, 0);
    for (int n = 1; n <= 12; n++) begin
`ifdef FREQ_PEAK_HOLD_EN
      e = (n <= 8) ? 280 : 280 + 4 * (n - 8);
`else
      e = 280 + 4 * n;
`endif
      frame(t1, t2);
      check($sformatf("b630_release_%0d", n), b630, e);
    end

    // Reset mid-commit discards the partial commit
    send(2, 16'h4000);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) check($sformatf("midreset_bar%0d", k), dut_bars[k], 480);
    check("midreset_in_ready", bus.in_ready, 1);
    check("midreset_commit_done", commit_done, 0);
    exp_q.delete();
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    frame(t1, t2);
    check("post_reset_b150", b150, 480);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("bad_band_drained", bad_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
